// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI controller slice.
package spi_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_SHIFT,
      ST_WAIT_TX,
      ST_HOLD,
      ST_GAP
   } spi_state_t;

   localparam int unsigned SPI_READ_BIT  = 7;
   localparam int unsigned SPI_REG_COUNT = 128;

endpackage

// File: rtl/spi_clock_divider.sv
// Half-period tick generator: tick pulses every CLK_DIV enabled cycles.
module spi_clock_divider #(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic enable,
   output logic tick
);

   localparam int unsigned CW = $clog2(CLK_DIV + 1);
   localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] count;

   assign tick = enable && (count == LAST);

   // Held at zero while disabled so every resume starts a full half-period.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         count <= '0;
      else if (!enable || tick)
         count <= '0;
      else
         count <= count + CW'(1);
   end

endmodule

// File: rtl/spi_controller.sv
// SPI mode-0 controller: address byte then byte_count_in data bytes.
// Receive path enabled by defining SPI_CONTROLLER_RX_EN.
module spi_controller
   import spi_pkg::*;
#(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic       clock_in,
   input  logic       reset_in,
   input  logic       start_in,
   input  logic [7:0] address_in,
   input  logic [7:0] byte_count_in,
   input  logic [7:0] tx_data_in,
   input  logic       tx_valid_in,
   output logic       tx_ready_out,
   output logic [7:0] rx_data_out,
   output logic       rx_valid_out,
   output logic       busy_out,
   output logic       done_out,
   output logic       spi_select_out,
   output logic       spi_clock_out,
   output logic       spi_data_out,
   input  logic       spi_data_in
);

   spi_state_t state, state_next;
   logic       tick, div_en, sclk;
   logic       rise, fall, byte_end;
   logic [7:0] shift;
   logic [2:0] bit_cnt;
   logic [8:0] byte_cnt;
   logic       addr_phase;

   spi_clock_divider #(.CLK_DIV(CLK_DIV)) u_div (
      .clk    (clock_in),
      .rst    (reset_in),
      .enable (div_en),
      .tick   (tick)
   );

   assign div_en   = (state == ST_SETUP) || (state == ST_SHIFT) ||
                     (state == ST_HOLD)  || (state == ST_GAP);
   assign rise     = (state == ST_SHIFT) && tick && !sclk;
   assign fall     = (state == ST_SHIFT) && tick && sclk;
   assign byte_end = fall && (bit_cnt == 3'd7);

   assign spi_select_out = !((state == ST_SETUP) || (state == ST_SHIFT) ||
                             (state == ST_WAIT_TX) || (state == ST_HOLD));
   assign spi_clock_out  = sclk;
   assign spi_data_out   = spi_select_out ? 1'b0 : shift[7];
   assign busy_out       = (state != ST_IDLE);

   always_ff @(posedge clock_in or posedge reset_in) begin
      if (reset_in)
         state <= ST_IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next   = state;
      tx_ready_out = 1'b0;
      done_out     = 1'b0;
      case (state)
         ST_IDLE:   if (start_in) state_next = ST_SETUP;
         ST_SETUP:  if (tick) state_next = ST_SHIFT;
         ST_SHIFT:
            if (byte_end) begin
               if (byte_cnt == 9'd1)
                  state_next = ST_HOLD;
               else if (tx_valid_in)
                  tx_ready_out = 1'b1;
               else
                  state_next = ST_WAIT_TX;
            end
         ST_WAIT_TX:
            if (tx_valid_in) begin
               tx_ready_out = 1'b1;
               state_next   = ST_SHIFT;
            end
         ST_HOLD:   if (tick) state_next = ST_GAP;
         ST_GAP:
            if (tick) begin
               done_out   = 1'b1;
               state_next = ST_IDLE;
            end
         default:   state_next = ST_IDLE;
      endcase
   end

   // byte_cnt holds bytes remaining including the one on the wire.
   always_ff @(posedge clock_in or posedge reset_in) begin
      if (reset_in) begin
         sclk       <= 1'b0;
         shift      <= '0;
         bit_cnt    <= '0;
         byte_cnt   <= '0;
         addr_phase <= 1'b0;
      end else begin
         if ((state == ST_IDLE) && start_in) begin
            shift      <= address_in;
            byte_cnt   <= {1'b0, byte_count_in} + 9'd1;
            bit_cnt    <= '0;
            addr_phase <= 1'b1;
         end
         if (rise)
            sclk <= 1'b1;
         if (fall) begin
            sclk <= 1'b0;
            if (bit_cnt == 3'd7) begin
               bit_cnt    <= '0;
               byte_cnt   <= byte_cnt - 9'd1;
               addr_phase <= 1'b0;
            end else begin
               bit_cnt <= bit_cnt + 3'd1;
               shift   <= {shift[6:0], 1'b0};
            end
         end
         if (tx_ready_out)
            shift <= tx_data_in;
      end
   end

`ifdef SPI_CONTROLLER_RX_EN
   logic [6:0] rx_shift;

   always_ff @(posedge clock_in or posedge reset_in) begin
      if (reset_in) begin
         rx_shift     <= '0;
         rx_data_out  <= '0;
         rx_valid_out <= 1'b0;
      end else begin
         rx_valid_out <= 1'b0;
         if (rise) begin
            if ((bit_cnt == 3'd7) && !addr_phase) begin
               rx_data_out  <= {rx_shift, spi_data_in};
               rx_valid_out <= 1'b1;
            end else begin
               rx_shift <= {rx_shift[5:0], spi_data_in};
            end
         end
      end
   end
`else
   logic unused_rx;
   assign unused_rx    = ^{spi_data_in, addr_phase};
   assign rx_data_out  = '0;
   assign rx_valid_out = 1'b0;
`endif

endmodule

// File: doc/spi_controller.md
SPI_CONTROLLER -- requirements
Module: spi_controller

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, clock_in cycles per SPI half-period (minimum 1).
REQ-002 SHALL have ports (clock and reset first):
- clock_in  input  1  system clock
- reset_in  input  1  asynchronous reset, active-high
- start_in  input  1  one-cycle transaction request
- address_in  input  8  address byte; bit 7 set means read
- byte_count_in  input  8  data bytes after the address; 0 means address only
- tx_data_in  input  8  next data byte to send
- tx_valid_in  input  1  tx_data_in valid
- tx_ready_out  output  1  tx byte accepted this cycle
- rx_data_out  output  8  last received data byte
- rx_valid_out  output  1  one-cycle pulse, rx_data_out updated
- busy_out  output  1  transaction in progress
- done_out  output  1  one-cycle pulse at transaction end
- spi_select_out  output  1  chip select, active low
- spi_clock_out  output  1  SPI clock
- spi_data_out  output  1  controller to device data
- spi_data_in  input  1  device to controller data

Function
REQ-003 SHALL use SPI mode 0: idle clock low; data driven while clock is low; sampled on the rising edge; MSB first.
REQ-004 SHALL implement states IDLE, SETUP, SHIFT, WAIT_TX, HOLD and GAP.
- IDLE -> SETUP on start_in; address_in and byte_count_in are latched.
- SETUP: select low for one half-period, then SHIFT.
- SHIFT: 8 bits per byte; address byte first, then byte_count_in data bytes.
- HOLD: clock low for one half-period, then select high.
- GAP: select high for one half-period, then IDLE with a done_out pulse.
REQ-005 SHALL ignore start_in while busy_out is 1.
REQ-006 busy_out SHALL be 1 from the cycle after start_in until the cycle done_out is asserted, inclusive.
REQ-007 At each data-byte boundary, for both write and read addresses, the controller SHALL consume one byte via handshake. tx_ready_out is 1 for exactly one cycle, and only while tx_valid_in is 1.
REQ-008 If tx_valid_in is 0 at a byte boundary, the controller SHALL enter WAIT_TX. In WAIT_TX the clock is held low, select stays low, and the controller waits indefinitely.
REQ-009 After the 8th rising edge of each data byte (never the address byte), rx_data_out SHALL update and rx_valid_out SHALL pulse once, within 2 clock_in cycles.
REQ-010 The clock divider counter SHALL be ceil(log2(CLK_DIV+1)) bits wide and wrap to 0 each half-period.
REQ-011 The byte counter SHALL be 9 bits, so that byte_count_in=255 plus the address byte does not overflow.
REQ-012 spi_data_out SHALL be 0 whenever select is high.
REQ-013 A transaction with byte_count_in=0 SHALL produce exactly 8 clock pulses, with no tx_ready_out or rx_valid_out.

Reset
REQ-014 While reset_in is 1, the controller SHALL go to IDLE immediately, asynchronously.
REQ-015 Reset values SHALL be:
- spi_select_out=1
- spi_clock_out=0
- spi_data_out=0
- busy_out=0, done_out=0
- tx_ready_out=0, rx_valid_out=0
- rx_data_out=0
REQ-016 Reset mid-transaction SHALL abort with no done_out pulse; a partial byte is discarded.

Configuration
REQ-017 With macro SPI_CONTROLLER_RX_EN defined, the receive path SHALL operate as specified.
REQ-018 Without SPI_CONTROLLER_RX_EN:
- spi_data_in SHALL be unused.
- rx_data_out SHALL be constant 0 and rx_valid_out constant 0.
- All other timing SHALL be unchanged.

Structure
REQ-019 Package spi_pkg SHALL hold the state enum type, SPI_READ_BIT=7, and SPI_REG_COUNT=128.
REQ-020 Sub-module spi_clock_divider SHALL generate the half-period tick; the shift logic and FSM stay in spi_controller.

Verification
REQ-021 The bench SHALL cover these scenarios with a device model:
- Write: CLK_DIV=2, address 0x05, count 2, tx 0xA5, 0x3C. Expect device regs[5]=0xA5, regs[6]=0x3C; 24 clock pulses; one done_out.
- Read: after the write above, address 0x85, count 2. Expect rx_valid_out twice, with rx_data_out 0xA5 then 0x3C.
- Stall: tx_valid_in held 0 for 50 cycles at byte 1. Expect clock low and select low throughout; transfer resumes correctly; no extra clock edges.
- Address only: count 0. Expect 8 clock pulses, tx_ready_out never 1, select high at end.
- Reset mid-operation: reset_in pulsed at bit 3 of byte 1. Expect select=1 and clock=0 asynchronously; no done_out; the next start works.
- Busy start: start_in asserted while busy. Expect it ignored; exactly one done_out.
